// File: rtl/ber_checker.sv
// Bit-error-rate checker: aligns the decoded stream to a delayed copy of the
// source stream, locks on the end-to-end latency, then counts errors per window.
module ber_checker #(
  parameter int MAX_DELAY = 63,
  parameter int SYNC_LEN  = 32,
  parameter int WINDOW    = 1024,
  parameter int LOSS_TH   = 256,
  localparam int DW = $clog2(MAX_DELAY + 1),
  localparam int CW = $clog2(WINDOW) + 1,
  localparam int SW = $clog2(SYNC_LEN + 1)
) (
  input  logic          clk_sig,
  input  logic          reset_sig,
  input  logic          bit_en,
  input  logic          ref_sig,
  input  logic          rx_sig,
  output logic          locked_sig,
  output logic [DW-1:0] delay_sig,
  output logic [CW-1:0] err_cnt_sig,
  output logic          done_sig,
  output logic          error_sig
);

  typedef enum logic [1:0] {
    FILL,
    SEARCH,
    LOCKED
  } state_e;

  state_e             state_q;
  logic [MAX_DELAY-1:0] dly_q;
  logic [DW-1:0]      fill_q;
  logic [SW-1:0]      sync_q;
  logic [CW-1:0]      bit_q;
  logic [CW-1:0]      werr_q;

  logic [MAX_DELAY:0] taps;
  logic               ref_sel;
  logic               mismatch;
  logic [CW-1:0]      bit_d;
  logic [CW-1:0]      werr_d;
  logic [DW-1:0]      delay_d;

  // Tap 0 is the live ref bit, tap k the bit accepted k enables ago.
  assign taps     = {dly_q, ref_sig};
  assign ref_sel  = taps[delay_sig];
  assign mismatch = bit_en & (rx_sig ^ ref_sel);
  assign bit_d    = bit_q + CW'(1);
  assign werr_d   = werr_q + CW'(mismatch);
  assign delay_d  = (delay_sig == DW'(MAX_DELAY)) ? '0
                  : delay_sig + DW'(1);

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      state_q     <= FILL;
      dly_q       <= '0;
      fill_q      <= '0;
      sync_q      <= '0;
      bit_q       <= '0;
      werr_q      <= '0;
      locked_sig  <= 1'b0;
      delay_sig   <= '0;
      err_cnt_sig <= '0;
      done_sig    <= 1'b0;
      error_sig   <= 1'b0;
    end else begin
      done_sig  <= 1'b0;
      error_sig <= 1'b0;
      if (bit_en) begin
        dly_q <= {dly_q[MAX_DELAY-2:0], ref_sig};
        unique case (state_q)
          FILL: begin
            if (fill_q == DW'(MAX_DELAY)) begin
              state_q   <= SEARCH;
              fill_q    <= '0;
              sync_q    <= '0;
              delay_sig <= '0;
            end else begin
              fill_q <= fill_q + DW'(1);
            end
          end
          SEARCH: begin
            if (mismatch) begin
              sync_q    <= '0;
              delay_sig <= delay_d;
            end else if (sync_q == SW'(SYNC_LEN - 1)) begin
              state_q    <= LOCKED;
              sync_q     <= '0;
              bit_q      <= '0;
              werr_q     <= '0;
              locked_sig <= 1'b1;
            end else begin
              sync_q <= sync_q + SW'(1);
            end
          end
          LOCKED: begin
            error_sig <= mismatch;
            if (bit_d == CW'(WINDOW)) begin
              err_cnt_sig <= werr_d;
              done_sig    <= 1'b1;
              bit_q       <= '0;
              werr_q      <= '0;
              // Lock is only judged on whole windows.
              if (werr_d > CW'(LOSS_TH)) begin
                state_q    <= SEARCH;
                sync_q     <= '0;
                delay_sig  <= '0;
                locked_sig <= 1'b0;
              end
            end else begin
              bit_q  <= bit_d;
              werr_q <= werr_d;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// Randomized scoreboard bench for ber_checker with a queue-based
// reference model of the delay search, lock and window counting.
module tb_ber_checker;

  logic        clk_sig = 1'b0;
  logic        reset_sig = 1'b0;
  logic        bit_en = 1'b0;
  logic        ref_sig = 1'b0;
  logic        rx_sig = 1'b0;
  logic        locked_sig;
  logic [5:0]  delay_sig;
  logic [10:0] err_cnt_sig;
  logic        done_sig;
  logic        error_sig;

  always #50 clk_sig = ~clk_sig;

  ber_checker dut (
    .clk_sig     (clk_sig),
    .reset_sig   (reset_sig),
    .bit_en      (bit_en),
    .ref_sig     (ref_sig),
    .rx_sig      (rx_sig),
    .locked_sig  (locked_sig),
    .delay_sig   (delay_sig),
    .err_cnt_sig (err_cnt_sig),
    .done_sig    (done_sig),
    .error_sig   (error_sig)
  );

  typedef struct packed {
    logic        lk;
    logic [5:0]  dl;
    logic [10:0] ec;
    logic        dn;
    logic        er;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  bit dat[8192];
  int idx = 0;
  int chan_d = 9;

  // reference model: 0 fill, 1 search, 2 locked
  int m_st, m_fill, m_dly, m_sync, m_bc, m_we, m_cnt;
  bit m_lock;
  bit hist[$];

  // observation trackers
  int   rises = 0, falls = 0, pulses = 0, dones = 0, wraps = 0;
  int   rise_idx = 0, rise_dly = 0, last_cnt = 0;
  logic prev_lk = 1'b0;
  logic [5:0] prev_dl = '0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic model(input bit rst_n, input bit en, input bit r,
                       input bit x, output bit dn, output bit er);
    bit mm;
    dn = 0;
    er = 0;
    if (!rst_n) begin
      m_st = 0; m_fill = 0; m_dly = 0; m_sync = 0;
      m_bc = 0; m_we = 0; m_cnt = 0; m_lock = 0;
      hist.delete();
      repeat (64) hist.push_back(1'b0);
      return;
    end
    if (!en) return;
    hist.push_front(r);
    mm = x ^ hist[m_dly];
    void'(hist.pop_back());
    if (m_st == 0) begin
      m_fill++;
      if (m_fill == 64) begin
        m_st = 1; m_fill = 0; m_dly = 0; m_sync = 0;
      end
    end else if (m_st == 1) begin
      if (mm) begin
        m_sync = 0;
        m_dly = (m_dly + 1) % 64;
      end else begin
        m_sync++;
        if (m_sync == 32) begin
          m_st = 2; m_lock = 1; m_bc = 0; m_we = 0; m_sync = 0;
        end
      end
    end else begin
      m_bc++;
      if (mm) begin
        m_we++;
        er = 1;
      end
      if (m_bc == 1024) begin
        m_cnt = m_we;
        dn = 1;
        if (m_we > 256) begin
          m_st = 1; m_dly = 0; m_sync = 0; m_lock = 0;
        end
        m_bc = 0;
        m_we = 0;
      end
    end
  endtask

  task automatic cycle(input bit rst_n, input bit en, input bit flip);
    bit   r, x, dn, er;
    obs_t e;
    @(negedge clk_sig);
    #1;
    r = en ? dat[idx] : 1'($urandom_range(0, 1));
    x = ((idx >= chan_d) ? dat[idx - chan_d] : 1'b0) ^ flip;
    reset_sig = rst_n;
    bit_en    = en;
    ref_sig   = r;
    rx_sig    = x;
    model(rst_n, en, r, x, dn, er);
    e.lk = m_lock;
    e.dl = 6'(m_dly);
    e.ec = 11'(m_cnt);
    e.dn = dn;
    e.er = er;
    exp_q.push_back(e);
    if (rst_n && en) idx++;
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    idx = 0;
  endtask

  always @(negedge clk_sig) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {locked_sig, delay_sig, err_cnt_sig, done_sig, error_sig};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL obs t=%0t: got lk=%b dl=%0d ec=%0d dn=%b er=%b, required lk=%b dl=%0d ec=%0d dn=%b er=%b",
                 $time, a.lk, a.dl, a.ec, a.dn, a.er,
                 e.lk, e.dl, e.ec, e.dn, e.er);
      end
    end
    if (locked_sig === 1'b1 && prev_lk !== 1'b1) begin
      rises++;
      rise_idx = idx;
      rise_dly = int'(delay_sig);
    end
    if (locked_sig === 1'b0 && prev_lk === 1'b1) falls++;
    if (error_sig === 1'b1) pulses++;
    if (done_sig === 1'b1) begin
      dones++;
      last_cnt = int'(err_cnt_sig);
    end
    if (prev_dl == 6'd63 && delay_sig == 6'd0) wraps++;
    prev_lk = locked_sig;
    prev_dl = delay_sig;
  end

  initial begin
    int n, lock_a, c;
    for (int i = 0; i < 8192; i++) dat[i] = 1'($urandom_range(0, 1));

    // run A: continuous enables, channel delay 9
    chan_d = 9;
    do_reset(3);
    cycle(1, 0, 0);
    chk("rst_locked", int'(locked_sig), 0);
    chk("rst_delay", int'(delay_sig), 0);
    chk("rst_errcnt", int'(err_cnt_sig), 0);
    rises = 0;
    n = 0;
    while (!m_lock && n < 600) begin
      cycle(1, 1, 0);
      n++;
    end
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("lock_rise", rises, 1);
    chk("lock_delay", rise_dly, 9);
    chk("lock_not_early", int'(rise_idx >= 64 + 9 + 32), 1);
    lock_a = rise_idx;

    dones = 0; pulses = 0;
    repeat (1024) cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("clean_done", dones, 1);
    chk("clean_cnt", last_cnt, 0);
    chk("clean_pulses", pulses, 0);

    dones = 0; pulses = 0;
    for (int k = 0; k < 1024; k++)
      cycle(1, 1, k == 10 || k == 200 || k == 400 || k == 700 || k == 1023);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("inj_pulses", pulses, 5);
    chk("inj_cnt", last_cnt, 5);
    repeat (1024) cycle(1, 1, 0);
    cycle(1, 0, 0);
    chk("after_inj_cnt", last_cnt, 0);

    // move channel latency: lock must drop and recover at 2
    chan_d = 2;
    falls = 0; rises = 0;
    repeat (1024) cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("loss_cnt_high", int'(last_cnt > 256), 1);
    chk("loss_fall", falls, 1);
    chk("loss_unlocked", int'(locked_sig), 0);
    n = 0;
    while (!m_lock && n < 1500) begin
      cycle(1, 1, 0);
      n++;
    end
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("relock", rises, 1);
    chk("relock_delay", int'(delay_sig), 2);

    // reset in the middle of a window
    repeat (500) cycle(1, 1, 0);
    do_reset(1);
    cycle(1, 0, 0);
    chk("midrst_locked", int'(locked_sig), 0);
    chk("midrst_delay", int'(delay_sig), 0);
    chk("midrst_errcnt", int'(err_cnt_sig), 0);
    chk("midrst_done", int'(done_sig), 0);
    chk("midrst_error", int'(error_sig), 0);

    // run B: same data, one enable in three cycles
    chan_d = 9;
    do_reset(2);
    rises = 0;
    n = 0;
    c = 0;
    while (!m_lock && n < 3000) begin
      cycle(1, c % 3 == 0, 0);
      c++;
      n++;
    end
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("gap_rise", rises, 1);
    chk("gap_lock_idx", rise_idx, lock_a);
    chk("gap_lock_delay", rise_dly, 9);
    dones = 0; pulses = 0;
    repeat (1024) begin
      cycle(1, 1, 0);
      cycle(1, 0, 0);
      cycle(1, 0, 0);
    end
    cycle(1, 0, 0);
    chk("gap_done", dones, 1);
    chk("gap_cnt", last_cnt, 0);
    chk("gap_pulses", pulses, 0);

    // latency beyond the search range never locks
    chan_d = 70;
    do_reset(2);
    rises = 0; wraps = 0;
    repeat (1500) cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("wide_no_lock", rises, 0);
    chk("wide_wraps", int'(wraps >= 2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
